// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode, funct and ALU control encodings for the decode stage and the ALU.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // Base (funct7 = 0) operation selected by funct3; shared by OP and OP-IMM.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read with writeback bypass, immediate generation and a
// one-entry valid/ready output register feeding the ALU.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    alu_op_e         dec_ctrl;
    logic            dec_ill;
    logic            accept;

    assign opcode = instr[6:0];
    assign dec_rd = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign shamt = {27'b0, instr[24:20]};

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data)
    );

    // A value being written back this cycle is not yet in the array, so forward it.
    assign rs1_val = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rf_a;
    assign rs2_val = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rf_b;

    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_ctrl = ALU_ADD;
        dec_ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_val;
                dec_b = rs2_val;
                if (f7 == F7_BASE) begin
                    dec_ctrl = alu_from_f3(f3);
                end else if ((f7 == F7_ALT) && (f3 == F3_ADD)) begin
                    dec_ctrl = ALU_SUB;
                end else if ((f7 == F7_ALT) && (f3 == F3_SR)) begin
                    dec_ctrl = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a    = rs1_val;
                dec_b    = imm_i;
                dec_ctrl = alu_from_f3(f3);
                if (f3 == F3_SLL) begin
                    dec_b   = shamt;
                    dec_ill = (f7 != F7_BASE);
                end else if (f3 == F3_SR) begin
                    dec_b = shamt;
                    if (f7 == F7_ALT) begin
                        dec_ctrl = ALU_SRA;
                    end else if (f7 != F7_BASE) begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        // Anything unsupported travels as a harmless ADD of zeros.
        if (dec_ill) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_ctrl = ALU_ADD;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Flush wins over a same-cycle capture; the dropped instruction is still consumed upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_ADD;
            rd        <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            alu_ctrl  <= dec_ctrl;
            rd        <= dec_rd;
            rd_we     <= !dec_ill && (dec_rd != 5'd0);
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then randomized traffic against a
// cycle-level reference model of the decode stage and register file.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic        m_known = 1'b0;
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        m_ill;

    id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ALU code of the plain (funct7 = 0) operation for a given funct3.
    function automatic logic [3:0] f3_code(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && (wb_rd == r)) return wb_data;
        return m_regs[r];
    endfunction

    task automatic ref_decode(input logic [31:0] ins, output logic [31:0] ea, output logic [31:0] eb,
                              output logic [3:0] ec, output logic ill);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] va;
        logic [31:0] vb;
        f7  = ins[31:25];
        f3  = ins[14:12];
        va  = read_reg(ins[19:15]);
        vb  = read_reg(ins[24:20]);
        ea  = 32'd0;
        eb  = 32'd0;
        ec  = 4'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h33: begin
                ea = va;
                eb = vb;
                if (f7 == 7'h00) ec = f3_code(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) ec = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) ec = 4'd7;
                else ill = 1'b1;
            end
            7'h13: begin
                ea = va;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    eb = 32'(ins[24:20]);
                    if (f7 == 7'h00) ec = f3_code(f3);
                    else if (f7 == 7'h20 && f3 == 3'd5) ec = 4'd7;
                    else ill = 1'b1;
                end else begin
                    eb = 32'($signed(ins[31:20]));
                    ec = f3_code(f3);
                end
            end
            7'h37: eb = {ins[31:12], 12'h000};
            7'h17: begin
                ea = pc;
                eb = {ins[31:12], 12'h000};
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ea = 32'd0;
            eb = 32'd0;
            ec = 4'd0;
        end
    endtask

    // One clock: check handshake, advance the model, then compare all registered outputs.
    task automatic cycle();
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ec;
        logic        ill;
        logic        acc;
        #1;
        if (m_known) checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready);
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_we = 0; m_ill = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                ref_decode(instr, ea, eb, ec, ill);
                m_valid = 1'b1;
                m_a = ea; m_b = eb; m_ctrl = ec; m_ill = ill;
                m_rd = instr[11:7];
                m_we = !ill && (instr[11:7] != 5'd0);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("alu_a", alu_a, m_a);
        checkOutput("alu_b", alu_b, m_b);
        checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        checkOutput("rd", 32'(rd), 32'(m_rd));
        checkOutput("rd_we", 32'(rd_we), 32'(m_we));
        checkOutput("illegal", 32'(illegal), 32'(m_ill));
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                                 input logic fl, input logic we, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic ordy, input logic r);
        in_valid  = iv;
        instr     = ins;
        pc        = p;
        flush     = fl;
        wb_en     = we;
        wb_rd     = wr;
        wb_data   = wd;
        out_ready = ordy;
        rst       = r;
        cycle();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        logic [31:0] ins;
        case ($urandom_range(0, 5))
            0: opc = 7'h33;
            1: opc = 7'h13;
            2: opc = 7'h13;
            3: opc = 7'h37;
            4: opc = 7'h17;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h10;
            default: f7 = 7'($urandom);
        endcase
        ins = $urandom;
        ins[31:25] = f7;
        ins[6:0]   = opc;
        return ins;
    endfunction

    initial begin
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Register setup through the write port, then SUB.
        applyStimulus(0, 0, 0, 0, 1, 5'd1, 32'd5, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd2, 32'd7, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 32'hFFFFFFF8, 1, 0);
        applyStimulus(1, 32'h402081B3, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("sub_a", alu_a, 32'd5);
        checkOutput("sub_b", alu_b, 32'd7);
        checkOutput("sub_ctrl", 32'(alu_ctrl), 32'd1);
        checkOutput("sub_rd", 32'(rd), 32'd3);

        applyStimulus(1, 32'h4012D213, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("srai_a", alu_a, 32'hFFFFFFF8);
        checkOutput("srai_ctrl", 32'(alu_ctrl), 32'd7);
        applyStimulus(1, 32'h2012D213, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("badshift_ill", 32'(illegal), 32'd1);
        applyStimulus(1, 32'h12345317, 32'h100, 0, 0, 0, 0, 1, 0);
        checkOutput("auipc_b", alu_b, 32'h12345000);
        applyStimulus(1, 32'h00100013, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("addi_x0_we", 32'(rd_we), 32'd0);

        // Bypass of a same-cycle writeback.
        applyStimulus(1, 32'h000083B3, 0, 0, 1, 5'd1, 32'hDEADBEEF, 1, 0);
        checkOutput("bypass_a", alu_a, 32'hDEADBEEF);

        // Backpressure for three cycles with a new instruction waiting, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h002081B3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h002081B3, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("release_a", alu_a, 32'hDEADBEEF);

        // Flush with a capture pending, then reset while holding.
        applyStimulus(1, 32'h402081B3, 0, 1, 0, 0, 0, 1, 0);
        applyStimulus(1, 32'h402081B3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h402081B3, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h000083B3, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("after_rst_a", alu_a, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
